// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined MIPS front end: next-PC select codes,
// reset/bubble defaults and the IF/ID payload layout.
package pipe_pkg;

    localparam logic [1:0] PCS_SEQ = 2'b00;
    localparam logic [1:0] PCS_BR  = 2'b01;
    localparam logic [1:0] PCS_JR  = 2'b10;
    localparam logic [1:0] PCS_J   = 2'b11;

    // sll $0,$0,0
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] inst;
        logic        valid;
        logic        misalign;
    } ifid_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pipe_ifid_reg.sv
// IF/ID pipeline register. Flush loads a bubble regardless of the write enable,
// so a stalled decode stage can still be cleared.
module pipe_ifid_reg
    import pipe_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        i_we,
    input  logic        i_flush,
    input  logic [31:0] i_pc4,
    input  logic [31:0] i_inst,
    input  logic        i_misalign,
    output logic [31:0] o_pc4,
    output logic [31:0] o_inst,
    output logic        o_valid,
    output logic        o_misalign
);

    ifid_t r_ifid;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_ifid <= '{pc4: 32'h0, inst: NOP_INST, valid: 1'b0, misalign: 1'b0};
        end else if (i_flush) begin
            r_ifid <= '{pc4: i_pc4, inst: NOP_INST, valid: 1'b0, misalign: 1'b0};
        end else if (i_we) begin
            r_ifid <= '{pc4: i_pc4, inst: i_inst, valid: 1'b1, misalign: i_misalign};
        end
    end

    assign o_pc4      = r_ifid.pc4;
    assign o_inst     = r_ifid.inst;
    assign o_valid    = r_ifid.valid;
    assign o_misalign = r_ifid.misalign;

endmodule

// File: rtl/pipe_fetch.sv
// Instruction-fetch stage: PC register, next-PC select, ROM address drive,
// IF/ID capture and a fetch performance counter.
module pipe_fetch
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    input  logic        wpcir,
    input  logic        flush,
    input  logic [31:0] imem_inst,
    output logic [31:0] imem_addr,
    output logic [31:0] id_pc4,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output logic        id_misalign,
    output logic [31:0] fetch_count
);

    logic [31:0] r_pc;
    logic [31:0] r_fetch_count;
    logic [31:0] w_pc4;
    logic [31:0] w_npc;
    logic        w_misalign;

    // Wraps naturally at 2^32; no overflow indication is wanted.
    assign w_pc4      = r_pc + 32'd4;
    assign w_misalign = is_misaligned(r_pc);

    always_comb begin
        w_npc = w_pc4;
        case (pcsource)
            PCS_SEQ: w_npc = w_pc4;
            PCS_BR:  w_npc = bpc;
            PCS_JR:  w_npc = rpc;
            PCS_J:   w_npc = jpc;
            default: w_npc = w_pc4;
        endcase
    end

    // Targets are loaded as given; misalignment is reported downstream.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pc <= RESET_PC;
        end else if (wpcir) begin
            r_pc <= w_npc;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_fetch_count <= 32'h0;
        end else if (wpcir && !flush) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    pipe_ifid_reg #(
        .NOP_INST (NOP_INST)
    ) u_ifid (
        .clock      (clock),
        .resetn     (resetn),
        .i_we       (wpcir),
        .i_flush    (flush),
        .i_pc4      (w_pc4),
        .i_inst     (imem_inst),
        .i_misalign (w_misalign),
        .o_pc4      (id_pc4),
        .o_inst     (id_inst),
        .o_valid    (id_valid),
        .o_misalign (id_misalign)
    );

    assign imem_addr   = r_pc;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_pipe_fetch.sv
// Directed bench for pipe_fetch; the ROM model returns its own address as data.
module tb_pipe_fetch;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] bpc = 32'h0;
    logic [31:0] rpc = 32'h0;
    logic [31:0] jpc = 32'h0;
    logic        wpcir = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] imem_inst;
    logic [31:0] imem_addr;
    logic [31:0] id_pc4;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        id_misalign;
    logic [31:0] fetch_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    assign imem_inst = imem_addr;

    pipe_fetch dut (
        .clock       (clock),
        .resetn      (resetn),
        .pcsource    (pcsource),
        .bpc         (bpc),
        .rpc         (rpc),
        .jpc         (jpc),
        .wpcir       (wpcir),
        .flush       (flush),
        .imem_inst   (imem_inst),
        .imem_addr   (imem_addr),
        .id_pc4      (id_pc4),
        .id_inst     (id_inst),
        .id_valid    (id_valid),
        .id_misalign (id_misalign),
        .fetch_count (fetch_count)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2 resetn = 1'b0;
        pcsource = 2'b00; wpcir = 1'b1; flush = 1'b0;
        #2 resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #3;
        n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want %h", imem_addr, 32'h0); end
        n_vec++; if (id_pc4 !== 32'h0) begin n_err++; $display("FAIL reset_pc4 got %h want %h", id_pc4, 32'h0); end
        n_vec++; if (id_inst !== 32'h0) begin n_err++; $display("FAIL reset_inst got %h want %h", id_inst, 32'h0); end
        n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", id_valid); end
        n_vec++; if (id_misalign !== 1'b0) begin n_err++; $display("FAIL reset_misalign got %b want 0", id_misalign); end
        n_vec++; if (fetch_count !== 32'h0) begin n_err++; $display("FAIL reset_count got %0d want 0", fetch_count); end
        $display("reset: pc=%h valid=%b count=%0d", imem_addr, id_valid, fetch_count);
        @(negedge clock);
        #2 resetn = 1'b1;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr [4] = '{32'h4, 32'h8, 32'hC, 32'h10};
        logic [31:0] exp_inst [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++; if (imem_addr !== exp_addr[i]) begin n_err++; $display("FAIL seq_addr%0d got %h want %h", i, imem_addr, exp_addr[i]); end
            n_vec++; if (id_pc4 !== exp_addr[i]) begin n_err++; $display("FAIL seq_pc4%0d got %h want %h", i, id_pc4, exp_addr[i]); end
            n_vec++; if (id_inst !== exp_inst[i]) begin n_err++; $display("FAIL seq_inst%0d got %h want %h", i, id_inst, exp_inst[i]); end
            n_vec++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL seq_valid%0d got %b want 1", i, id_valid); end
            $display("seq: pc=%h id_inst=%h id_pc4=%h count=%0d", imem_addr, id_inst, id_pc4, fetch_count);
        end
        n_vec++; if (fetch_count !== 32'd4) begin n_err++; $display("FAIL seq_count got %0d want 4", fetch_count); end
    endtask

    task automatic test_stall();
        wpcir = 1'b0;
        pcsource = 2'b01; bpc = 32'h80;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++; if (imem_addr !== 32'h10) begin n_err++; $display("FAIL stall_pc%0d got %h want %h", i, imem_addr, 32'h10); end
            n_vec++; if (id_inst !== 32'hC) begin n_err++; $display("FAIL stall_inst%0d got %h want %h", i, id_inst, 32'hC); end
            n_vec++; if (fetch_count !== 32'd4) begin n_err++; $display("FAIL stall_count%0d got %0d want 4", i, fetch_count); end
            $display("stall: pc=%h id_inst=%h count=%0d", imem_addr, id_inst, fetch_count);
        end
        wpcir = 1'b1; pcsource = 2'b00;
        step();
        n_vec++; if (imem_addr !== 32'h14) begin n_err++; $display("FAIL resume_pc got %h want %h", imem_addr, 32'h14); end
        n_vec++; if (id_inst !== 32'h10) begin n_err++; $display("FAIL resume_inst got %h want %h", id_inst, 32'h10); end
        n_vec++; if (id_pc4 !== 32'h14) begin n_err++; $display("FAIL resume_pc4 got %h want %h", id_pc4, 32'h14); end
        n_vec++; if (fetch_count !== 32'd5) begin n_err++; $display("FAIL resume_count got %0d want 5", fetch_count); end
        $display("resume: pc=%h id_inst=%h count=%0d", imem_addr, id_inst, fetch_count);
    endtask

    task automatic test_branch();
        do_reset();
        step(); step();
        pcsource = 2'b01; bpc = 32'h40;
        step();
        n_vec++; if (imem_addr !== 32'h40) begin n_err++; $display("FAIL br_pc got %h want %h", imem_addr, 32'h40); end
        n_vec++; if (id_inst !== 32'h8) begin n_err++; $display("FAIL br_inst got %h want %h", id_inst, 32'h8); end
        n_vec++; if (id_pc4 !== 32'hC) begin n_err++; $display("FAIL br_pc4 got %h want %h", id_pc4, 32'hC); end
        $display("branch: pc=%h id_inst=%h id_pc4=%h", imem_addr, id_inst, id_pc4);
        pcsource = 2'b00;
        step();
        n_vec++; if (imem_addr !== 32'h44) begin n_err++; $display("FAIL br_next_pc got %h want %h", imem_addr, 32'h44); end
        n_vec++; if (id_inst !== 32'h40) begin n_err++; $display("FAIL br_next_inst got %h want %h", id_inst, 32'h40); end
        n_vec++; if (fetch_count !== 32'd4) begin n_err++; $display("FAIL br_count got %0d want 4", fetch_count); end
        $display("branch+1: pc=%h id_inst=%h count=%0d", imem_addr, id_inst, fetch_count);
    endtask

    task automatic test_flush();
        wpcir = 1'b0; flush = 1'b1;
        step();
        n_vec++; if (id_inst !== 32'h0) begin n_err++; $display("FAIL fl_stall_inst got %h want %h", id_inst, 32'h0); end
        n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL fl_stall_valid got %b want 0", id_valid); end
        n_vec++; if (imem_addr !== 32'h44) begin n_err++; $display("FAIL fl_stall_pc got %h want %h", imem_addr, 32'h44); end
        n_vec++; if (fetch_count !== 32'd4) begin n_err++; $display("FAIL fl_stall_count got %0d want 4", fetch_count); end
        $display("flush/stall: pc=%h valid=%b count=%0d", imem_addr, id_valid, fetch_count);
        wpcir = 1'b1; flush = 1'b0;
        step();
        n_vec++; if (id_inst !== 32'h44 || id_valid !== 1'b1) begin n_err++; $display("FAIL fl_refetch got %h/%b want %h/1", id_inst, id_valid, 32'h44); end
        n_vec++; if (fetch_count !== 32'd5) begin n_err++; $display("FAIL fl_refetch_count got %0d want 5", fetch_count); end
        flush = 1'b1;
        step();
        n_vec++; if (imem_addr !== 32'h4C) begin n_err++; $display("FAIL fl_adv_pc got %h want %h", imem_addr, 32'h4C); end
        n_vec++; if (id_valid !== 1'b0 || id_pc4 !== 32'h4C) begin n_err++; $display("FAIL fl_adv_ifid got %b/%h want 0/%h", id_valid, id_pc4, 32'h4C); end
        n_vec++; if (fetch_count !== 32'd5) begin n_err++; $display("FAIL fl_adv_count got %0d want 5", fetch_count); end
        $display("flush/advance: pc=%h valid=%b count=%0d", imem_addr, id_valid, fetch_count);
        flush = 1'b0;
    endtask

    task automatic test_wrap_misalign();
        pcsource = 2'b11; jpc = 32'hFFFF_FFFC;
        step();
        n_vec++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL jmp_pc got %h want %h", imem_addr, 32'hFFFF_FFFC); end
        pcsource = 2'b00;
        step();
        n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_pc got %h want %h", imem_addr, 32'h0); end
        n_vec++; if (id_pc4 !== 32'h0) begin n_err++; $display("FAIL wrap_pc4 got %h want %h", id_pc4, 32'h0); end
        n_vec++; if (id_inst !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_inst got %h want %h", id_inst, 32'hFFFF_FFFC); end
        $display("wrap: pc=%h id_pc4=%h id_inst=%h", imem_addr, id_pc4, id_inst);
        pcsource = 2'b11; jpc = 32'h22;
        step();
        n_vec++; if (imem_addr !== 32'h22 || id_misalign !== 1'b0) begin n_err++; $display("FAIL mis_jmp got %h/%b want %h/0", imem_addr, id_misalign, 32'h22); end
        jpc = 32'h100;
        step();
        n_vec++; if (id_inst !== 32'h22 || id_misalign !== 1'b1) begin n_err++; $display("FAIL mis_flag got %h/%b want %h/1", id_inst, id_misalign, 32'h22); end
        n_vec++; if (id_pc4 !== 32'h26) begin n_err++; $display("FAIL mis_pc4 got %h want %h", id_pc4, 32'h26); end
        $display("misalign: id_inst=%h misalign=%b", id_inst, id_misalign);
        pcsource = 2'b00;
        step();
        n_vec++; if (id_inst !== 32'h100 || id_misalign !== 1'b0) begin n_err++; $display("FAIL mis_clear got %h/%b want %h/0", id_inst, id_misalign, 32'h100); end
        pcsource = 2'b10; rpc = 32'h200;
        step();
        n_vec++; if (imem_addr !== 32'h200) begin n_err++; $display("FAIL jr_pc got %h want %h", imem_addr, 32'h200); end
        $display("jr: pc=%h id_inst=%h", imem_addr, id_inst);
        pcsource = 2'b00;
    endtask

    task automatic test_async_reset();
        wpcir = 1'b0;
        step();
        #2 resetn = 1'b0;
        #1;
        n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL areset_pc got %h want %h", imem_addr, 32'h0); end
        n_vec++; if (id_pc4 !== 32'h0 || id_inst !== 32'h0) begin n_err++; $display("FAIL areset_ifid got %h/%h want 0/0", id_pc4, id_inst); end
        n_vec++; if (id_valid !== 1'b0 || id_misalign !== 1'b0) begin n_err++; $display("FAIL areset_flags got %b/%b want 0/0", id_valid, id_misalign); end
        n_vec++; if (fetch_count !== 32'h0) begin n_err++; $display("FAIL areset_count got %0d want 0", fetch_count); end
        $display("async reset: pc=%h valid=%b count=%0d", imem_addr, id_valid, fetch_count);
        wpcir = 1'b1;
        #1 resetn = 1'b1;
        step();
        n_vec++; if (imem_addr !== 32'h4 || id_valid !== 1'b1 || id_pc4 !== 32'h4) begin n_err++; $display("FAIL post_reset got %h/%b/%h want 4/1/4", imem_addr, id_valid, id_pc4); end
        n_vec++; if (fetch_count !== 32'd1) begin n_err++; $display("FAIL post_reset_count got %0d want 1", fetch_count); end
        $display("post reset: pc=%h valid=%b count=%0d", imem_addr, id_valid, fetch_count);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_flush();
        test_wrap_misalign();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
